// File: rtl/clock_source_select_pkg.sv
// Shared definitions for the clock-source selector.
//   DEFAULT_DIVISOR : system-clock cycles per divided-clock period
//   SEL_DIV/SEL_PGT : encodings of the select input
//   cnt_width()     : divider counter width for a given divisor
package clock_select_pkg;

  localparam int DEFAULT_DIVISOR = 100;

  localparam logic SEL_DIV = 1'b1;
  localparam logic SEL_PGT = 1'b0;

  // Smallest width w (at least 1) such that 2**w >= divisor.
  function automatic int cnt_width(input int divisor);
    int w;
    w = 1;
    while ((1 << w) < divisor) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/clock_source_select_if.sv
// Signal bundle between the selector and its surroundings.
//   pgt      : external pulse, asynchronous to the system clock
//   select   : 1 = divided clock, 0 = pgt
//   out      : selected clock/pulse (registered)
//   div_clk  : free-running divided clock, 50 % duty
//   div_tick : one-cycle strobe on the last cycle of each divided period
// master drives pgt/select, slave (the selector) drives the outputs.
interface clock_source_select_if;

  logic pgt;
  logic select;
  logic out;
  logic div_clk;
  logic div_tick;

  modport master (
    output pgt,
    output select,
    input  out,
    input  div_clk,
    input  div_tick
  );

  modport slave (
    input  pgt,
    input  select,
    output out,
    output div_clk,
    output div_tick
  );

endinterface

// File: rtl/clock_source_select_rate_divider.sv
// rate_divider: free-running modulo-DIVISOR counter producing a 50 %-duty
// divided clock and a strobe on the last count of each period.
//   clock    : system clock
//   reset_n  : asynchronous active-low reset
//   div_clk  : low for the first DIVISOR/2 counts, high for the rest
//   div_tick : high while the counter equals DIVISOR-1
module rate_divider
  import clock_select_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR,
  parameter int CNT_W   = cnt_width(DIVISOR)
) (
  input  logic clock,
  input  logic reset_n,
  output logic div_clk,
  output logic div_tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DIVISOR / 2 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_clk_q, div_clk_d;
  logic             div_tick_q, div_tick_d;

  // Next-state: wrap the counter, toggle div_clk when leaving either
  // half-period end point, and raise the strobe for the cycle in which the
  // counter will sit on its last value.
  always_comb begin
    cnt_d      = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
    div_clk_d  = div_clk_q;
    if ((cnt_q == LAST_CNT) || (cnt_q == HALF_CNT)) begin
      div_clk_d = ~div_clk_q;
    end
    div_tick_d = (cnt_d == LAST_CNT);
  end

  // Divider state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      div_clk_q  <= 1'b0;
      div_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_clk_q  <= div_clk_d;
      div_tick_q <= div_tick_d;
    end
  end

  assign div_clk  = div_clk_q;
  assign div_tick = div_tick_q;

endmodule

// File: rtl/clock_source_select.sv
// clock_source_select: derives a slow divided clock from the system clock and
// drives a registered output from either that clock or the synchronized
// external pulse pgt.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of clock_source_select_if (pgt, select in;
//             out, div_clk, div_tick out)
// Switching select is immediate; truncated phases on out are acceptable.
module clock_source_select
  import clock_select_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR,
  parameter int CNT_W   = cnt_width(DIVISOR)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  clock_source_select_if.slave  bus
);

  logic div_clk_w;
  logic div_tick_w;

  rate_divider #(
    .DIVISOR (DIVISOR),
    .CNT_W   (CNT_W)
  ) u_rate_divider (
    .clock    (clock),
    .reset_n  (reset_n),
    .div_clk  (div_clk_w),
    .div_tick (div_tick_w)
  );

  logic pgt_meta_q, pgt_meta_d;
  logic pgt_s_q, pgt_s_d;
  logic out_q, out_d;

  // Two-flop synchronizer for pgt, then the output mux. The mux uses the
  // registered div_clk, so out lags div_clk by one cycle.
  always_comb begin
    pgt_meta_d = bus.pgt;
    pgt_s_d    = pgt_meta_q;
    out_d      = (bus.select == SEL_DIV) ? div_clk_w : pgt_s_q;
  end

  // Synchronizer and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pgt_meta_q <= 1'b0;
      pgt_s_q    <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      pgt_meta_q <= pgt_meta_d;
      pgt_s_q    <= pgt_s_d;
      out_q      <= out_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.div_clk  = div_clk_w;
  assign bus.div_tick = div_tick_w;

endmodule

// File: tb/tb_clock_source_select.sv
// Testbench for clock_source_select with DIVISOR = 4.
// A reference model derives expected outputs from the number of clock edges
// since reset release and the history of sampled inputs; literal vectors pin
// the model against hand-derived waveforms.
module tb_clock_source_select;

  localparam int D = 4;

  logic clock;
  logic reset_n;

  clock_source_select_if bus ();

  clock_source_select #(
    .DIVISOR (D),
    .CNT_W   (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // 10 ns clock; rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int assertCount;
  int failCount;

  // Compares one value and reports a failure.
  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives select/pgt at the current (falling-edge) time and holds them
  // for the given number of cycles.
  task automatic applyStimulus(input logic sel, input logic p, input int cycles);
    bus.select = sel;
    bus.pgt    = p;
    repeat (cycles) @(negedge clock);
  endtask

  // ------------------------------------------------------------------
  // Reference model. k counts rising edges since reset release; after
  // edge k the divider sits at phase k mod D, div_clk is high in the upper
  // half of the period and the strobe marks phase D-1. out after edge k is
  // what select chose at edge k: either div_clk as it was after edge k-1,
  // or pgt as sampled two edges earlier (zero before enough history exists).
  // ------------------------------------------------------------------
  int   k;
  bit   pgtHist[$];
  logic expOut, expDivClk, expDivTick;

  function automatic logic divClkAt(input int n);
    return ((n % D) >= D / 2) ? 1'b1 : 1'b0;
  endfunction

  initial begin
    k = 0;
    expOut = 1'b0;
    expDivClk = 1'b0;
    expDivTick = 1'b0;
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k = 0;
      pgtHist.delete();
      expOut = 1'b0;
      expDivClk = 1'b0;
      expDivTick = 1'b0;
    end else begin
      k++;
      pgtHist.push_back(bus.pgt);
      expDivClk  = divClkAt(k);
      expDivTick = ((k % D) == D - 1) ? 1'b1 : 1'b0;
      if (bus.select) expOut = divClkAt(k - 1);
      else            expOut = (k >= 3) ? logic'(pgtHist[k - 3]) : 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (reset_n && k > 0) begin
      checkOutput("model_div_clk", bus.div_clk, expDivClk);
      checkOutput("model_div_tick", bus.div_tick, expDivTick);
      checkOutput("model_out", bus.out, expOut);
    end
  end

  // Hand-derived waveforms for edges 1..7 after reset with select=1, pgt=0.
  int pinDivClk[7]  = '{0, 1, 1, 0, 0, 1, 1};
  int pinOut[7]     = '{0, 0, 1, 1, 0, 0, 1};
  int pinDivTick[7] = '{0, 0, 1, 0, 0, 0, 1};

  int ticks;
  int highs;

  // Directed scenario sequence.
  initial begin
    assertCount = 0;
    failCount = 0;
    bus.select = 1'b1;
    bus.pgt = 1'b0;
    reset_n = 1'b0;

    // Reset values.
    repeat (2) @(negedge clock);
    checkOutput("reset_out", bus.out, 0);
    checkOutput("reset_div_clk", bus.div_clk, 0);
    checkOutput("reset_div_tick", bus.div_tick, 0);

    // Divided-clock pattern after release.
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      checkOutput("pin_div_clk", bus.div_clk, pinDivClk[i]);
      checkOutput("pin_out", bus.out, pinOut[i]);
      checkOutput("pin_div_tick", bus.div_tick, pinDivTick[i]);
    end

    // pgt held high 5 cycles with select=0: out rises/falls 3 cycles later.
    applyStimulus(1'b0, 1'b0, 3);
    bus.pgt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("pgt_rise_out", bus.out, (i >= 2) ? 1 : 0);
    end
    bus.pgt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("pgt_fall_out", bus.out, (i < 2) ? 1 : 0);
    end

    // select switched 1 -> 0 -> 1 mid-period.
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 5);

    // select toggling every cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i % 2) == 0, 1'b0, 1);
    end

    // Sub-cycle pgt glitch between edges, then a 2-cycle pulse.
    applyStimulus(1'b0, 1'b0, 1);
    #2 bus.pgt = 1'b1;
    #2 bus.pgt = 1'b0;
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b0, 1'b0, 5);

    // Asynchronous reset while the counter is at 2.
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    bus.select = 1'b1;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("pre_async_div_clk", bus.div_clk, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_div_clk", bus.div_clk, 0);
    checkOutput("async_div_tick", bus.div_tick, 0);
    checkOutput("async_out", bus.out, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("restart_edge1_div_clk", bus.div_clk, 0);
    @(negedge clock);
    checkOutput("restart_edge2_div_clk", bus.div_clk, 1);

    // Long run: tick count and duty cycle.
    bus.select = 1'b1;
    ticks = 0;
    highs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      ticks += int'(bus.div_tick);
      highs += int'(bus.div_clk);
    end
    checkOutput("long_tick_count", ticks, 250);
    checkOutput("long_high_cycles", highs, 500);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/clock_source_select.md
# clock_source_select

Clock-source selector for the microwave timer datapath. Derives a slow 50 %-duty divided clock (nominally 1 Hz) from the system clock and drives a single output from either that divided clock or an external pulse input `pgt`, chosen by `select`. Sits between the system clock generator and the countdown/timer logic, so the timer advances either automatically (divided clock) or by manual pulses.

## Interface
- `DIVISOR`, default 100: system-clock cycles per divided-clock period; must be even and ≥ 2.
- `CNT_W`, default 7: divider counter width; must satisfy 2^CNT_W ≥ DIVISOR.
- `clock`  input  1  system clock; all logic on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `pgt`  input  1  external pulse, asynchronous to `clock`.
- `select`  input  1  1 = divided clock, 0 = `pgt`; synchronous to `clock`.
- `out`  output  1  selected clock/pulse, registered.
- `div_clk`  output  1  free-running divided clock, 50 % duty.
- `div_tick`  output  1  one-cycle strobe on the last cycle of each divided period.

## Operation
- One clock domain; reset is asynchronous and active-low.
- Reset (while `reset_n`=0): counter=0, `div_clk`=0, `div_tick`=0, both `pgt` sync flops=0, `out`=0.
- Divider: counter counts 0..DIVISOR-1 and wraps to 0.
  - `div_clk` toggles on the edge where the counter leaves DIVISOR/2-1 and on the edge where it leaves DIVISOR-1.
  - Result: high for DIVISOR/2 cycles, then low for DIVISOR/2 cycles.
  - `div_tick` = 1 for exactly the one cycle where the counter equals DIVISOR-1.
- Divider runs continuously, independent of `select`.
- `pgt` passes through a 2-flop synchronizer to give `pgt_s`.
- Output register: `out` <= `select` ? `div_clk` : `pgt_s`.
- Switching `select` takes effect immediately, with no glitch-free handover. A truncated high or low phase on `out` at the switch point is accepted.
- `pgt` pulses shorter than one `clock` period may be lost. A `pgt` level held for at least 2 cycles is guaranteed to reach `out`.

## Timing
- `select` to `out`: 1 cycle.
- `pgt` to `out`: 3 cycles (2 synchronizer + 1 output register).
- `div_clk` to `out` (with `select`=1): 1 cycle.
- After `reset_n` rises, the first `div_clk` rising edge occurs on clock edge DIVISOR/2. It is visible on `out` one cycle later.
- `reset_n` asserted mid-period: counter and all outputs clear at once. The next period restarts from count 0.
- `select` toggling every cycle: `out` follows each toggle with 1-cycle latency.

## Structure
- Shared package `clock_select_pkg`:
  - `DEFAULT_DIVISOR` = 100.
  - `SEL_DIV` = 1'b1 and `SEL_PGT` = 1'b0.
  - Helper function for counter width (ceil log2 of DIVISOR).
- One sub-module, `rate_divider`:
  - Contains the counter and generates `div_clk` and `div_tick`.
  - Parameterised by `DIVISOR`.
- Synchronizer and output mux register live in the top module.

## Test plan
All scenarios use DIVISOR=4.
- Reset then run with `select`=1, `pgt`=0 -> `div_clk` pattern from edge 1 is 0,1,1,0,0,1,1,…; `out` is the same pattern delayed 1 cycle; `div_tick` high once every 4 cycles, on cycles where the counter = 3.
- `select`=0, `pgt` 0→1 held 5 cycles then 0 -> `out` rises 3 cycles after the `pgt` edge and falls 3 cycles after the falling edge; `div_clk` keeps toggling every 2 cycles.
- `select` switched 1→0→1 mid-period with `pgt`=0 -> `out`=0 one cycle after the switch to 0; `out` resumes tracking `div_clk` 1 cycle after the switch back; divider phase unaffected.
- `pgt` single-cycle glitch aligned between clock edges -> no requirement; checker only requires that any pulse ≥ 2 cycles appears on `out` with equal width.
- `reset_n` pulled low asynchronously with counter = 2 -> `out`, `div_clk` and `div_tick` go 0 without waiting for a clock edge; after release the first `div_clk` rise is at edge 2.
- Long run (1000 cycles) with `select`=1 -> exactly 250 `div_tick` pulses; `div_clk` duty exactly 50 %.
